// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB/HALT control FSM with Moore output decode.
// Define CTRL_SINGLE_STEP_EN to add a step input that gates each instruction fetch.
module multicycle_controller (
    input  logic       clk,
    input  logic       Rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [4:0] opcode,
    input  logic [1:0] ALUopcode,
    input  logic [2:0] PSW_NZC,
    output logic       Buff_MEMIns,
    output logic       MEMresource,
    output logic       WE_MEM,
    output logic       ALUorNot,
    output logic       LIorMOV,
    output logic       WBresource,
    output logic       RBresource,
    output logic       oprandB,
    output logic       LI,
    output logic       PCplus1orWB,
    output logic       WE_RF,
    output logic       Flag,
    output logic       ALUop,
    output logic       Buff_PSW,
    output logic       Branch,
    output logic [1:0] Jump,
    output logic       Buff_PC,
    output logic       done,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;
    state_t     st;
    logic [4:0] op_q;
    logic [1:0] alu_q;
    logic       go;
`ifdef CTRL_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif
    logic is_lli, is_lhi, is_ldri, is_ldrr, is_stri, is_strr, is_alu, is_jmp, is_bc, is_hlt;
    logic is_imm, is_ld, is_st, to_exec, taken;
    assign is_lli  = op_q == 5'b00001;
    assign is_lhi  = op_q == 5'b00010;
    assign is_ldri = op_q == 5'b00011;
    assign is_ldrr = op_q == 5'b00100;
    assign is_stri = op_q == 5'b00101;
    assign is_strr = op_q == 5'b00110;
    assign is_alu  = op_q == 5'b00111;
    assign is_jmp  = op_q == 5'b01001;
    assign is_bc   = op_q == 5'b01010;
    assign is_hlt  = op_q == 5'b11111;
    assign is_imm  = is_lli | is_lhi;
    assign is_ld   = is_ldri | is_ldrr;
    assign is_st   = is_stri | is_strr;
    assign to_exec = is_imm | is_ld | is_st | is_alu;
    // Condition codes: 00=Z, 01=!Z, 10=C, 11=N with flags packed {N,Z,C}
    assign taken   = alu_q[1] ? (alu_q[0] ? PSW_NZC[2] : PSW_NZC[0]) : (PSW_NZC[1] ^ alu_q[0]);
    assign state   = st;
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            st    <= FETCH;
            op_q  <= '0;
            alu_q <= '0;
        end else begin
            case (st)
                FETCH: if (go) begin
                    st    <= DECODE;
                    op_q  <= opcode;
                    alu_q <= ALUopcode;
                end
                DECODE:  st <= is_hlt ? HALT : (to_exec ? EXEC : FETCH);
                EXEC:    st <= MEM;
                MEM:     st <= is_st ? FETCH : WB;
                WB:      st <= FETCH;
                HALT:    st <= HALT;
                default: st <= FETCH;
            endcase
        end
    end
    always_comb begin
        Buff_MEMIns = 1'b0;
        MEMresource = 1'b0;
        WE_MEM      = 1'b0;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        PCplus1orWB = 1'b0;
        WE_RF       = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Branch      = 1'b0;
        Jump        = 2'b00;
        Buff_PC     = 1'b0;
        done        = 1'b0;
        case (st)
            FETCH: Buff_MEMIns = go;
            DECODE: begin
                RBresource = is_lhi;
                LI         = is_lhi;
                oprandB    = is_ldri | is_stri;
                Jump       = {1'b0, is_jmp};
                Branch     = is_bc & taken;
                Buff_PC    = !(is_hlt | to_exec);
            end
            EXEC: begin
                Flag     = is_alu & alu_q[0];
                ALUop    = is_alu & alu_q[1];
                Buff_PSW = is_alu;
            end
            MEM: begin
                ALUorNot    = is_imm;
                MEMresource = is_ld | is_st;
                WE_MEM      = is_st;
                Buff_PC     = is_st;
            end
            WB: begin
                WE_RF       = 1'b1;
                PCplus1orWB = 1'b1;
                Buff_PC     = 1'b1;
                WBresource  = is_ld;
            end
            HALT:    done = 1'b1;
            default: done = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction stream with a per-cycle expected-output scoreboard.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic Rst = 1'b0;
    logic [4:0] opcode = '0;
    logic [1:0] ALUopcode = '0;
    logic [2:0] PSW_NZC = '0;
    logic Buff_MEMIns, MEMresource, WE_MEM, ALUorNot, LIorMOV, WBresource, RBresource, oprandB;
    logic LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW, Branch, Buff_PC, done;
    logic [1:0] Jump;
    logic [2:0] state;
    int n_chk = 0;
    int n_fail = 0;
    logic [21:0] eq[$];
    string nq[$];
    localparam logic [18:0] IMS = 19'd1 << 18, MRS = 19'd1 << 17, WEM = 19'd1 << 16, AON = 19'd1 << 15;
    localparam logic [18:0] WBR = 19'd1 << 13, RBR = 19'd1 << 12, OPB = 19'd1 << 11, LIH = 19'd1 << 10;
    localparam logic [18:0] PCW = 19'd1 << 9, WRF = 19'd1 << 8, FLG = 19'd1 << 7, AOP = 19'd1 << 6;
    localparam logic [18:0] PSW = 19'd1 << 5, BR = 19'd1 << 4, JMP = 19'd1 << 2, PC = 19'd1 << 1, DN = 19'd1;
    localparam logic [18:0] WBV = WRF | PCW | PC;

    multicycle_controller dut (
        .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
        .Buff_MEMIns(Buff_MEMIns), .MEMresource(MEMresource), .WE_MEM(WE_MEM), .ALUorNot(ALUorNot),
        .LIorMOV(LIorMOV), .WBresource(WBresource), .RBresource(RBresource), .oprandB(oprandB),
        .LI(LI), .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF), .Flag(Flag), .ALUop(ALUop),
        .Buff_PSW(Buff_PSW), .Branch(Branch), .Jump(Jump), .Buff_PC(Buff_PC), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {Buff_MEMIns, MEMresource, WE_MEM, ALUorNot, LIorMOV, WBresource, RBresource, oprandB,
                  LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW, Branch, Jump, Buff_PC, done};

    task automatic chk(input string n, input logic [21:0] got, input logic [21:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     n, got[21:19], got[18:0], exp[21:19], exp[18:0]);
        end
    endtask

    always @(negedge clk) begin
        if (eq.size() > 0) chk(nq.pop_front(), {state, obs}, eq.pop_front());
    end

    task automatic push(input string n, input logic [2:0] s, input logic [18:0] v);
        eq.push_back({s, v});
        nq.push_back(n);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one instruction at the start of its FETCH cycle; expected outputs per state follow.
    task automatic ins(input string n, input logic [4:0] op, input logic [1:0] a, input logic [2:0] f,
                       input int len, input logic [18:0] d, input logic [18:0] e,
                       input logic [18:0] m, input logic [18:0] w);
        opcode = op;
        ALUopcode = a;
        PSW_NZC = f;
        push({n, "_fetch"}, 3'd0, IMS);
        push({n, "_decode"}, 3'd1, d);
        if (len > 2) push({n, "_exec"}, 3'd2, e);
        if (len > 3) push({n, "_mem"}, 3'd3, m);
        if (len > 4) push({n, "_wb"}, 3'd4, w);
        run(1);
        opcode = ~op;
        ALUopcode = ~a;
        run(len - 1);
    endtask

    initial begin
        #2;
        chk("reset_state", {19'd0, state}, 22'd0);
        chk("reset_done", {21'd0, done}, 22'd0);
        @(posedge clk);
        #1;
        Rst = 1'b1;
        ins("lli", 5'b00001, 2'b00, 3'b000, 5, 19'd0, 19'd0, AON, WBV);
        ins("lhi", 5'b00010, 2'b00, 3'b000, 5, RBR | LIH, 19'd0, AON, WBV);
        ins("ldrri", 5'b00011, 2'b00, 3'b000, 5, OPB, 19'd0, MRS, WBV | WBR);
        ins("ldrrr", 5'b00100, 2'b00, 3'b000, 5, 19'd0, 19'd0, MRS, WBV | WBR);
        ins("strri", 5'b00101, 2'b00, 3'b000, 4, OPB, 19'd0, MRS | WEM | PC, 19'd0);
        ins("strrr", 5'b00110, 2'b00, 3'b000, 4, 19'd0, 19'd0, MRS | WEM | PC, 19'd0);
        ins("add", 5'b00111, 2'b00, 3'b000, 5, 19'd0, PSW, 19'd0, WBV);
        ins("adc", 5'b00111, 2'b01, 3'b000, 5, 19'd0, PSW | FLG, 19'd0, WBV);
        ins("sub", 5'b00111, 2'b10, 3'b000, 5, 19'd0, PSW | AOP, 19'd0, WBV);
        ins("sbb", 5'b00111, 2'b11, 3'b000, 5, 19'd0, PSW | FLG | AOP, 19'd0, WBV);
        ins("outr", 5'b01000, 2'b00, 3'b000, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("jmp", 5'b01001, 2'b00, 3'b000, 2, JMP | PC, 19'd0, 19'd0, 19'd0);
        ins("beq_t", 5'b01010, 2'b00, 3'b010, 2, BR | PC, 19'd0, 19'd0, 19'd0);
        ins("beq_n", 5'b01010, 2'b00, 3'b000, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("bne_n", 5'b01010, 2'b01, 3'b010, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("bne_t", 5'b01010, 2'b01, 3'b101, 2, BR | PC, 19'd0, 19'd0, 19'd0);
        ins("bcs_t", 5'b01010, 2'b10, 3'b001, 2, BR | PC, 19'd0, 19'd0, 19'd0);
        ins("bcs_n", 5'b01010, 2'b10, 3'b110, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("bmi_t", 5'b01010, 2'b11, 3'b100, 2, BR | PC, 19'd0, 19'd0, 19'd0);
        ins("bmi_n", 5'b01010, 2'b11, 3'b011, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("nop_a", 5'b01011, 2'b00, 3'b000, 2, PC, 19'd0, 19'd0, 19'd0);
        ins("nop_b", 5'b10000, 2'b00, 3'b000, 2, PC, 19'd0, 19'd0, 19'd0);
        opcode = 5'b11111;
        ALUopcode = 2'b00;
        PSW_NZC = 3'b000;
        push("hlt_fetch", 3'd0, IMS);
        push("hlt_decode", 3'd1, 19'd0);
        for (int i = 0; i < 20; i++) push("hlt_halt", 3'd5, DN);
        run(22);
        Rst = 1'b0;
        #1;
        chk("halt_rst_state", {19'd0, state}, 22'd0);
        chk("halt_rst_done", {21'd0, done}, 22'd0);
        #1;
        Rst = 1'b1;
        opcode = 5'b00101;
        push("strri_r_fetch", 3'd0, IMS);
        push("strri_r_decode", 3'd1, OPB);
        push("strri_r_exec", 3'd2, 19'd0);
        run(3);
        #1;
        Rst = 1'b0;
        push("mem_rst", 3'd0, IMS);
        #1;
        chk("mem_rst_state", {19'd0, state}, 22'd0);
        chk("mem_rst_we_mem", {21'd0, WE_MEM}, 22'd0);
        chk("mem_rst_buff_pc", {21'd0, Buff_PC}, 22'd0);
        @(posedge clk);
        #2;
        Rst = 1'b1;
        ins("post_rst_lli", 5'b00001, 2'b00, 3'b000, 5, 19'd0, 19'd0, AON, WBV);
        #1;
        chk("scoreboard_drained", 22'(eq.size()), 22'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. It SHALL have no parameters.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 Rst  in  1  asynchronous reset, active-low.
REQ-004 opcode  in  5  instruction opcode from the datapath instruction register.
REQ-005 ALUopcode  in  2  ALU operation or branch condition from the instruction register.
REQ-006 PSW_NZC  in  3  registered flags {N,Z,C}.
REQ-007 Buff_MEMIns  out  1  load instruction register.
REQ-008 MEMresource  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-009 WE_MEM  out  1  memory write enable.
REQ-010 ALUorNot  out  1  result-register source: 1 = immediate path, 0 = ALU.
REQ-011 LIorMOV  out  1  immediate-path select.
REQ-012 WBresource  out  1  writeback source: 0 = result register, 1 = memory.
REQ-013 RBresource  out  1  read-port-B address select.
REQ-014 oprandB  out  1  ALU B operand: 1 = immediate, 0 = register.
REQ-015 LI  out  1  immediate half: 0 = low, 1 = high.
REQ-016 PCplus1orWB  out  1  register-file write-data select.
REQ-017 WE_RF  out  1  register-file write enable.
REQ-018 Flag  out  1  carry/borrow-in enable.
REQ-019 ALUop  out  1  0 = add, 1 = subtract.
REQ-020 Buff_PSW  out  1  load PSW.
REQ-021 Branch  out  1  take PC-relative branch.
REQ-022 Jump  out  2  jump select: 00 = none, 01 = absolute.
REQ-023 Buff_PC  out  1  load PC.
REQ-024 done  out  1  processor halted.
REQ-025 state  out  3  current state code, for debug.

Function
REQ-026 The states SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-027 Every output SHALL be a Moore-style combinational decode of state and the latched opcode fields; any output not asserted by a rule below SHALL be 0 (never x).
REQ-028 In FETCH, the block SHALL drive Buff_MEMIns=1 and MEMresource=0, then go to DECODE.
REQ-029 The block SHALL latch opcode and ALUopcode on the DECODE entry edge and use the latched copy until the next FETCH.
REQ-030 Opcode map: 00001 LLI, 00010 LHI, 00011 LDRri, 00100 LDRrr, 00101 STRri, 00110 STRrr, 00111 ALU, 01000 OUTR, 01001 JMP, 01010 BCOND, 11111 HLT; all other opcodes SHALL be NOPs.
REQ-031 DECODE outputs: LHI gives RBresource=1, LI=1; LDRri/STRri give oprandB=1; LDRrr/STRrr/ALU give RBresource=0, oprandB=0.
REQ-032 DECODE exits:
- OUTR and NOP: assert Buff_PC, go to FETCH.
- JMP: assert Jump=01 and Buff_PC, go to FETCH.
- BCOND: assert Branch and Buff_PC when the condition holds (ALUopcode 00=Z, 01=!Z, 10=C, 11=N), else Buff_PC only; go to FETCH.
- HLT: go to HALT.
- All others: go to EXEC.
REQ-033 EXEC for ALU SHALL assert Buff_PSW=1 with {Flag,ALUop} = ADD 00, ADC 10, SUB 01, SBB 11 (ALUopcode 00/01/10/11); for loads and stores, EXEC SHALL drive Flag=0, ALUop=0, Buff_PSW=0.
REQ-034 MEM outputs: LLI/LHI give ALUorNot=1, LIorMOV=0; ALU gives ALUorNot=0; loads give MEMresource=1; stores give MEMresource=1, WE_MEM=1, Buff_PC=1 and then go to FETCH.
REQ-035 WB SHALL assert WE_RF=1, PCplus1orWB=1, Buff_PC=1, with WBresource=1 for loads and 0 otherwise, then go to FETCH.
REQ-036 Instruction latency, counted from FETCH entry to the next FETCH:
- LLI, LHI, LDR*, ALU: 5 cycles.
- STR*: 4 cycles.
- OUTR, JMP, BCOND, NOP: 2 cycles.
REQ-037 HALT SHALL hold done=1 with all other outputs 0 until reset; WE_RF, WE_MEM and Buff_PC SHALL never be asserted in the same cycle as Buff_MEMIns.

Reset
REQ-038 Rst=0 SHALL immediately force state to FETCH, done to 0 and the latched fields to 0, independent of clk.
REQ-039 Reset asserted mid-instruction SHALL abort the instruction; no WE_RF, WE_MEM or Buff_PC pulse SHALL occur while Rst=0.
REQ-040 After Rst is released, the first rising edge SHALL be a FETCH cycle.

Configuration
REQ-041 With CTRL_SINGLE_STEP_EN defined, the block SHALL add an input step (1 bit) and remain in FETCH with all outputs 0 until step=1 is sampled; that fetch then executes, and exactly one instruction runs per step pulse.
REQ-042 Without CTRL_SINGLE_STEP_EN, the step port SHALL be absent and FETCH SHALL never stall.

Verification
REQ-043 Reset, then opcode=00001 -> states 0,1,2,3,4; the WB cycle has WE_RF=1, PCplus1orWB=1, Buff_PC=1, WBresource=0.
REQ-044 opcode=00111, ALUopcode=11 -> the EXEC cycle has Flag=1, ALUop=1, Buff_PSW=1; the instruction completes in 5 cycles.
REQ-045 opcode=00101 -> the MEM cycle has MEMresource=1, WE_MEM=1, Buff_PC=1; the next state is FETCH (4 cycles total).
REQ-046 opcode=01010, ALUopcode=00, PSW_NZC=3'b010 -> the DECODE cycle has Branch=1, Buff_PC=1; with PSW_NZC=3'b000 -> Branch=0, Buff_PC=1.
REQ-047 opcode=11111 -> HALT follows DECODE, done=1 is held for 20 cycles, and no Buff_PC pulse occurs.
REQ-048 Rst=0 pulsed during the MEM cycle of STRri -> state is 0 within the same cycle, WE_MEM=0, and FETCH follows release.
